cjb_cpu_step_ctrl: RTL
======================

# cjb_cpu_step_ctrl

- Execution-rate controller for the RISC core on the DE0-Nano build.
- Replaces the free-running divided CPU clock with a single-cycle clock-enable pulse (`Cpu_clk_en`) on `Clk_50`.
- Provides halt, push-button single-step, slow-run and fast-run modes, plus a post-reset CPU reset hold and an executed-cycle counter.
- Sits between the board I/O (push-button, switches) and the processor's clock-enable and reset inputs.

## Interface

Parameters:
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a push-button level change (10 ms at 50 MHz).
- `SLOW_DIV`, default 50000000: `Clk_50` cycles between enables in slow-run mode (1 Hz).
- `FAST_DIV`, default 5000000: `Clk_50` cycles between enables in fast-run mode (10 Hz).
- `RST_HOLD`, default 16: cycles `Cpu_reset` stays asserted after `Reset` deasserts.

Ports:
- `Clk_50`  in  1  board clock; all state on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Step_pb`  in  1  raw step push-button, active-low, asynchronous to `Clk_50`.
- `Mode`  in  2  raw switches, asynchronous: 00 halt, 01 single-step, 10 slow-run, 11 fast-run.
- `Halt_req`  in  1  synchronous from the CPU; level-high requests a stop.
- `Cpu_clk_en`  out  1  one-cycle enable; the CPU advances one cycle per pulse.
- `Cpu_reset`  out  1  active-high synchronous reset to the CPU.
- `Running`  out  1  high in the RUN state.
- `Cycle_cnt`  out  16  count of issued `Cpu_clk_en` pulses.

## Operation

- **Synchronizers:** `Step_pb` and `Mode` each pass through a 2-FF synchronizer.
- **Mode change:** `Mode` is sampled at the synchronizer output. A change of the synchronized `Mode` clears the rate counter that cycle.
- **Debounce:** the debounced button level (reset 1 = released) updates only after the synchronized level has differed from it for `DB_CYCLES` consecutive cycles. Any agreeing sample clears the debounce counter.
- **Step request:** a debounced 1→0 transition raises `step_req` for exactly one cycle.
- **State machine:** RST_HOLD, HALT, STEP, RUN.
  - RST_HOLD: entered asynchronously on `Reset`=0. `Cpu_reset`=1. Leaves after `RST_HOLD` cycles with `Reset`=1, going to HALT.
  - HALT: no enables. Go to RUN if synchronized `Mode`[1]=1 and `Halt_req`=0. Go to STEP if `Mode`=01 and `step_req`=1.
  - STEP: issues exactly one `Cpu_clk_en`, then returns to HALT the next cycle.
  - RUN: rate counter counts 0..DIV-1, where DIV = `SLOW_DIV` if `Mode`=10, `FAST_DIV` if `Mode`=11. `Cpu_clk_en`=1 in the cycle the counter equals DIV-1, and the counter wraps to 0. Return to HALT if `Mode`[1]=0 or `Halt_req`=1; no enable is issued in that exit cycle.
- **Simultaneous events:**
  - `Halt_req`=1 and a terminal count in the same cycle: halt wins, no pulse.
  - `step_req` outside `Mode`=01: discarded.
  - `step_req` arriving while in STEP: discarded; no queuing.
- **Cycle counter:** `Cycle_cnt` increments by 1 on every `Cpu_clk_en` pulse and wraps 0xFFFF→0x0000. It clears only in RST_HOLD.
- **Reset mid-operation:** any state goes immediately (asynchronously) to RST_HOLD. A pending step or partial rate count is lost.

## Timing

- Reset values:
  - `Cpu_clk_en`=0, `Cpu_reset`=1, `Running`=0, `Cycle_cnt`=0.
  - Debounced level = 1; all counters = 0.
- All outputs are registered.
- `Cpu_reset` falls at the `RST_HOLD`-th rising edge after `Reset` rises. HALT is entered on that same edge.
- Step latency: a press held stable produces the `Cpu_clk_en` pulse 2 (sync) + `DB_CYCLES` + 2 (edge, STEP) cycles after the first low sample.
- Run entry:
  - The first enable comes DIV cycles after entering RUN.
  - Enable spacing is exactly DIV cycles.
  - A fast/slow switch restarts the spacing from the switch cycle.
- `Running` is high in exactly the cycles the FSM is in RUN.
- `Cpu_clk_en` is never high in two consecutive cycles when DIV ≥ 2.
- `Cpu_clk_en` is never high while `Cpu_reset`=1.

## Test plan

Bench parameters: `DB_CYCLES`=4, `SLOW_DIV`=10, `FAST_DIV`=3, `RST_HOLD`=4.

1. **Reset:** assert `Reset`=0 mid-RUN, release → `Cpu_reset`=1 for exactly 4 cycles after release, `Cycle_cnt`=0, no `Cpu_clk_en` until `Mode` selects run.
2. **Single-step with bounce:** `Mode`=01; `Step_pb` toggles 3 times at 1-cycle spacing, then held low for 20 cycles → exactly one `Cpu_clk_en` pulse, `Cycle_cnt`=1; release and press again cleanly → `Cycle_cnt`=2.
3. **Slow run:** `Mode`=10 for 55 cycles after HALT → enables every 10 cycles, 5 pulses total. Switch to `Mode`=11 → next pulse 3 cycles after the synchronized change, then every 3.
4. **Halt priority:** in fast-run, assert `Halt_req` on the cycle the counter is 2 → no pulse that cycle, `Running`=0 next cycle. Deassert → RUN resumes, first pulse 3 cycles later.
5. **Mode gating:** press `Step_pb` while `Mode`=00 or 10 → no extra pulse. `Mode`=00 from RUN → HALT within 3 cycles, no pulses afterwards.
6. **Counter wrap:** preload via 65536 fast-run pulses → `Cycle_cnt` reads 0x0000 after the 65536th pulse.

Source files
------------

// File: rtl/cjb_cpu_step_ctrl.sv
// Execution-rate controller: turns board switches and a step button into a
// one-cycle CPU clock enable on Clk_50, with post-reset hold and a cycle counter.
module cjb_cpu_step_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int SLOW_DIV  = 50000000,
  parameter int FAST_DIV  = 5000000,
  parameter int RST_HOLD  = 16
) (
  input  logic        Clk_50,
  input  logic        Reset,
  input  logic        Step_pb,
  input  logic [1:0]  Mode,
  input  logic        Halt_req,
  output logic        Cpu_clk_en,
  output logic        Cpu_reset,
  output logic        Running,
  output logic [15:0] Cycle_cnt
);

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int RATE_W  = $clog2(DIV_MAX + 1);
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W  = $clog2(RST_HOLD + 1);

  localparam logic [RATE_W-1:0] SLOW_TERM = RATE_W'(SLOW_DIV - 1);
  localparam logic [RATE_W-1:0] FAST_TERM = RATE_W'(FAST_DIV - 1);
  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_RST_HOLD, S_HALT, S_STEP, S_RUN} state_t;

  logic              pb_p0, pb_p1;
  logic [1:0]        mode_p0, mode_p1, mode_d;
  logic              db_level, db_prev, step_req;
  logic [DB_W-1:0]   db_cnt;
  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [RATE_W-1:0] rate_cnt, rate_next, rate_eff, div_term;
  logic              mode_chg, term, en_next;

  // Stage p0/p1: two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge Clk_50 or negedge Reset) begin
    if (!Reset) begin
      pb_p0   <= 1'b1;
      pb_p1   <= 1'b1;
      mode_p0 <= 2'b00;
      mode_p1 <= 2'b00;
      mode_d  <= 2'b00;
    end else begin
      pb_p0   <= Step_pb;
      pb_p1   <= pb_p0;
      mode_p0 <= Mode;
      mode_p1 <= mode_p0;
      mode_d  <= mode_p1;
    end
  end

  // Debounce, then a registered falling-edge detector producing step_req
  always_ff @(posedge Clk_50 or negedge Reset) begin
    if (!Reset) begin
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      db_prev  <= db_level;
      step_req <= db_prev & ~db_level;
      if (pb_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TERM) begin
        db_level <= pb_p1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // The cycle a mode change appears counts as rate count zero, so the spacing restarts there
  assign mode_chg = (mode_p1 != mode_d);
  assign rate_eff = mode_chg ? '0 : rate_cnt;
  assign div_term = (mode_p1 == 2'b11) ? FAST_TERM : SLOW_TERM;
  assign term     = (rate_eff == div_term);

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    rate_next  = '0;
    en_next    = 1'b0;
    case (state)
      S_RST_HOLD: begin
        if (hold_cnt == HOLD_TERM) state_next = S_HALT;
        else                       hold_next  = hold_cnt + 1'b1;
      end
      S_HALT: begin
        if (mode_p1[1] && !Halt_req) begin
          state_next = S_RUN;
        end else if (mode_p1 == 2'b01 && step_req) begin
          state_next = S_STEP;
          en_next    = 1'b1;
        end
      end
      S_STEP: state_next = S_HALT;
      S_RUN: begin
        // Exit has priority over a terminal count
        if (!mode_p1[1] || Halt_req) state_next = S_HALT;
        else if (term)               en_next    = 1'b1;
        else                         rate_next  = rate_eff + 1'b1;
      end
      default: state_next = S_HALT;
    endcase
  end

  // Output stage: every output is a flop loaded from the next-state decode
  always_ff @(posedge Clk_50 or negedge Reset) begin
    if (!Reset) begin
      state      <= S_RST_HOLD;
      hold_cnt   <= '0;
      rate_cnt   <= '0;
      Cpu_clk_en <= 1'b0;
      Cpu_reset  <= 1'b1;
      Running    <= 1'b0;
      Cycle_cnt  <= '0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      rate_cnt   <= rate_next;
      Cpu_clk_en <= en_next;
      Cpu_reset  <= (state_next == S_RST_HOLD);
      Running    <= (state_next == S_RUN);
      Cycle_cnt  <= (state == S_RST_HOLD) ? 16'h0000 : Cycle_cnt + 16'(en_next);
    end
  end

endmodule
